sync_fifo_flags: RTL and testbench

Parametrised single-clock FIFO: the next generation of `syn_fifo`. It adds:
- configurable width and depth,
- an occupancy count,
- programmable almost-full and almost-empty thresholds,
- overflow and underflow error pulses,
- a selectable first-word-fall-through (FWFT) read mode.

It sits between a producer and a consumer in one clock domain. It keeps the `wr_cs`/`wr_en` and `rd_cs`/`rd_en` qualification scheme of `syn_fifo`.

---
 rtl/sync_fifo_flags.sv | 104 ++++++++++
 tb/tb_sync_fifo_flags.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with occupancy count, threshold flags and error pulses
// Registered status flags derived from next count; optional first-word-fall-through read port.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2,
  parameter bit FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_cs,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_cs,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  wr_req;
  logic                  rd_req;
  logic                  wr_ok;
  logic                  rd_ok;

  // Acceptance uses the registered flags, so a same-cycle read never frees room for a write.
  always_comb begin
    wr_req     = wr_cs & wr_en;
    rd_req     = rd_cs & rd_en;
    wr_ok      = wr_req & ~full;
    rd_ok      = rd_req & ~empty;
    count_next = count;
    if (wr_ok && !rd_ok) begin
      count_next = count + CNT_ONE;
    end else if (rd_ok && !wr_ok) begin
      count_next = count - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count        <= count_next;
      full         <= (count_next == DEPTH_C);
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= AF_C);
      almost_empty <= (count_next <= AE_C);
      overflow     <= wr_req & full;
      underflow    <= rd_req & empty;
    end
  end

  // Storage is intentionally not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) begin
      mem[wr_ptr] <= data_in;
    end
  end

  if (FWFT) begin : g_fwft
    assign data_out = mem[rd_ptr];
  end else begin : g_std
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_out <= '0;
      end else if (rd_ok) begin
        data_out <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - directed self-checking bench for sync_fifo_flags
// Two instances: u_std (registered read) and u_fwft (first-word-fall-through).
module tb_sync_fifo_flags;

  logic       clk;
  logic       rst;
  logic       wr_cs, wr_en, rd_cs, rd_en;
  logic [7:0] data_in, data_out;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0] count;
  logic       f_wr_cs, f_wr_en, f_rd_cs, f_rd_en;
  logic [7:0] f_data_in, f_data_out;
  logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [2:0] f_count;
  int         n_checks;
  int         n_fail;

  sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1'b0)) u_std (
    .clk(clk), .rst(rst), .wr_cs(wr_cs), .wr_en(wr_en), .data_in(data_in),
    .rd_cs(rd_cs), .rd_en(rd_en), .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .wr_cs(f_wr_cs), .wr_en(f_wr_en), .data_in(f_data_in),
    .rd_cs(f_rd_cs), .rd_en(f_rd_en), .data_out(f_data_out), .full(f_full), .empty(f_empty),
    .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
    .overflow(f_overflow), .underflow(f_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [7:0] d);
    wr_cs   = w;
    wr_en   = w;
    rd_cs   = r;
    rd_en   = r;
    data_in = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b want=1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b want=0", full); end
    n_checks++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ae got=%b want=1", almost_empty); end
    n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af got=%b want=0", almost_full); end
    n_checks++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_err got=%b%b want=00", overflow, underflow); end
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout got=%h want=00", data_out); end
    n_checks++; if (f_empty !== 1'b1) begin n_fail++; $display("FAIL reset_fwft_empty got=%b want=1", f_empty); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    drive(1'b1, 1'b0, 8'h07);
    tick();
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count got=%0d want=1", count); end
    n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL single_empty got=%b want=0", empty); end
    n_checks++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL single_ae got=%b want=1", almost_empty); end
    drive(1'b0, 1'b1, 8'h00);
    tick();
    n_checks++; if (data_out !== 8'h07) begin n_fail++; $display("FAIL single_dout got=%h want=07", data_out); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty2 got=%b want=1", empty); end
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_fill_overflow();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic       af_exp [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       full_exp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, vals[i]);
      tick();
      n_checks++; if (count !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d] got=%0d want=%0d", i, count, i + 1); end
      n_checks++; if (almost_full !== af_exp[i]) begin n_fail++; $display("FAIL fill_af[%0d] got=%b want=%b", i, almost_full, af_exp[i]); end
      n_checks++; if (full !== full_exp[i]) begin n_fail++; $display("FAIL fill_full[%0d] got=%b want=%b", i, full, full_exp[i]); end
    end
    drive(1'b1, 1'b0, 8'h55);
    tick();
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse got=%b want=1", overflow); end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_count got=%0d want=4", count); end
    drive(1'b0, 1'b0, 8'h00);
    tick();
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b want=0", overflow); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      tick();
      n_checks++; if (data_out !== vals[i]) begin n_fail++; $display("FAIL drain_dout[%0d] got=%h want=%h", i, data_out, vals[i]); end
    end
    drive(1'b0, 1'b0, 8'h00);
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got=%b want=1", empty); end
  endtask

  task automatic test_underflow();
    drive(1'b0, 1'b1, 8'h00);
    tick();
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_pulse got=%b want=1", underflow); end
    n_checks++; if (data_out !== 8'h44) begin n_fail++; $display("FAIL unf_dout_hold got=%h want=44", data_out); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL unf_count got=%0d want=0", count); end
    drive(1'b0, 1'b0, 8'h00);
    tick();
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clear got=%b want=0", underflow); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q [6] = '{8'h81, 8'h82, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
    drive(1'b1, 1'b0, 8'h81);
    tick();
    drive(1'b1, 1'b0, 8'h82);
    tick();
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_pre_count got=%0d want=2", count); end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 8'hA0 + 8'(i));
      tick();
      n_checks++; if (data_out !== exp_q[i]) begin n_fail++; $display("FAIL b2b_dout[%0d] got=%h want=%h", i, data_out, exp_q[i]); end
      n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count[%0d] got=%0d want=2", i, count); end
      n_checks++; if ({full, empty, almost_full, almost_empty} !== 4'b0000) begin
        n_fail++; $display("FAIL b2b_flags[%0d] got=%b want=0000", i, {full, empty, almost_full, almost_empty});
      end
    end
    drive(1'b0, 1'b1, 8'h00);
    tick();
    n_checks++; if (data_out !== 8'hA4) begin n_fail++; $display("FAIL b2b_tail0 got=%h want=a4", data_out); end
    tick();
    n_checks++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL b2b_tail1 got=%h want=a5", data_out); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty got=%b want=1", empty); end
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_fwft();
    f_wr_cs = 1'b1; f_wr_en = 1'b1; f_data_in = 8'h5A;
    tick();
    n_checks++; if (f_empty !== 1'b0) begin n_fail++; $display("FAIL fwft_empty got=%b want=0", f_empty); end
    n_checks++; if (f_data_out !== 8'h5A) begin n_fail++; $display("FAIL fwft_head got=%h want=5a", f_data_out); end
    f_data_in = 8'h6B;
    tick();
    n_checks++; if (f_data_out !== 8'h5A) begin n_fail++; $display("FAIL fwft_head_hold got=%h want=5a", f_data_out); end
    n_checks++; if (f_count !== 3'd2) begin n_fail++; $display("FAIL fwft_count2 got=%0d want=2", f_count); end
    f_wr_cs = 1'b0; f_wr_en = 1'b0; f_rd_cs = 1'b1; f_rd_en = 1'b1;
    tick();
    n_checks++; if (f_data_out !== 8'h6B) begin n_fail++; $display("FAIL fwft_next got=%h want=6b", f_data_out); end
    n_checks++; if (f_count !== 3'd1) begin n_fail++; $display("FAIL fwft_count1 got=%0d want=1", f_count); end
    f_rd_cs = 1'b0; f_rd_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 8'hC1 + 8'(i));
      tick();
    end
    drive(1'b0, 1'b0, 8'h00);
    n_checks++; if (almost_full !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_af got=%b want=1", almost_full); end
    #3;
    rst = 1'b1;
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rstmid_count got=%0d want=0", count); end
    n_checks++; if ({empty, full, almost_full} !== 3'b100) begin
      n_fail++; $display("FAIL rstmid_flags got=%b want=100", {empty, full, almost_full});
    end
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b1, 8'h00);
    tick();
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL rstmid_unf got=%b want=1", underflow); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rstmid_count2 got=%0d want=0", count); end
    drive(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    f_wr_cs = 1'b0; f_wr_en = 1'b0; f_rd_cs = 1'b0; f_rd_en = 1'b0; f_data_in = 8'h00;
    test_reset();
    test_single();
    test_fill_overflow();
    test_underflow();
    test_back_to_back();
    test_fwft();
    test_reset_mid();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
